// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// mode encoding and the group-count helpers used at elaboration.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int num_groups(input int width, input int group_w);
    return width / group_w;
  endfunction

  function automatic bit width_ok(input int width, input int group_w);
    return (group_w > 0) && (width >= group_w) && ((width % group_w) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP_W-bit carry-lookahead slice; every carry is a flat function of
// the group's generate/propagate terms and cin, with no ripple through c[i].
module cla_group #(
  parameter int GROUP_W = 4
) (
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W:0]   c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded per bit
    for (int i = 0; i < GROUP_W; i++) begin
      c[i+1] = cin;
      for (int j = 0; j <= i; j++) begin
        c[i+1] = (c[i+1] & p[j]) | g[j];
      end
    end
  end

  assign sum   = p ^ c[GROUP_W-1:0];
  assign cout  = c[GROUP_W];
  assign c_msb = c[GROUP_W-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract: one lookahead group resolved per stage, registered
// inter-group carries, valid/ready stream with a global stall.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int GROUP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int NG = num_groups(WIDTH, GROUP_W);

  if (!width_ok(WIDTH, GROUP_W)) begin : g_bad_width
    $error("WIDTH must be a non-zero multiple of GROUP_W");
  end

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] bx0;
  logic             c0;

  assign en      = !o_valid || o_ready;
  assign i_ready = en && rst;
  assign accept  = i_valid && i_ready;
  assign bx0     = i_add2 ^ {WIDTH{i_sub == MODE_SUB}};
  assign c0      = i_cin ^ i_sub;

  // Stage k holds: res_q = sums of groups 0..k, operand A above that;
  // bx_q = the still-unresolved upper groups of B (absent in the last stage).
  for (genvar k = 0; k < NG; k++) begin : g_stage
    localparam int BW_IN = WIDTH - k * GROUP_W;

    logic [WIDTH-1:0]   res_in;
    logic [BW_IN-1:0]   bx_in;
    logic               carry_in;
    logic               valid_in;
    logic [GROUP_W-1:0] grp_sum;
    logic               grp_cout;
    logic               grp_cmsb;
    logic [WIDTH-1:0]   res_nxt;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic               valid_q;

    if (k == 0) begin : g_src
      assign res_in   = i_add1;
      assign bx_in    = bx0;
      assign carry_in = c0;
      assign valid_in = accept;
    end else begin : g_src
      assign res_in   = g_stage[k-1].res_q;
      assign bx_in    = g_stage[k-1].g_bx.bx_q;
      assign carry_in = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
    end

    cla_group #(.GROUP_W(GROUP_W)) u_group (
      .a     (res_in[k*GROUP_W +: GROUP_W]),
      .b     (bx_in[GROUP_W-1:0]),
      .cin   (carry_in),
      .sum   (grp_sum),
      .cout  (grp_cout),
      .c_msb (grp_cmsb)
    );

    always_comb begin
      // NOTE: assign the whole vector before patching one slice, so every bit is driven on every path and no latch is inferred.
      res_nxt                         = res_in;
      res_nxt[k*GROUP_W +: GROUP_W]   = grp_sum;
    end

    // NOTE: stage registers use non-blocking assignments so every stage samples the previous stage's old value on the same edge.
    always_ff @(posedge clk) begin
      // NOTE: data registers are cleared too, because o_result must read 0 after reset, not just o_valid.
      if (!rst) begin
        valid_q <= 1'b0;
        res_q   <= '0;
        carry_q <= 1'b0;
      end else if (en) begin
        valid_q <= valid_in;
        res_q   <= res_nxt;
        carry_q <= grp_cout;
      end
    end

    if (k < NG - 1) begin : g_bx
      logic [BW_IN-GROUP_W-1:0] bx_q;
      logic                     unused_c_msb;

      assign unused_c_msb = grp_cmsb;

      always_ff @(posedge clk) begin
        if (!rst) begin
          bx_q <= '0;
        end else if (en) begin
          bx_q <= bx_in[BW_IN-1:GROUP_W];
        end
      end
    end else begin : g_ovf
      // Overflow is only meaningful in the group holding the sign bit.
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= grp_cout ^ grp_cmsb;
        end
      end
    end
  end

  assign o_valid    = g_stage[NG-1].valid_q;
  assign o_result   = {g_stage[NG-1].carry_q, g_stage[NG-1].res_q};
  assign o_overflow = g_stage[NG-1].g_ovf.ovf_q;

endmodule
